// File: rtl/alu_exec_unit.sv
// Y86-64 execute unit: single-cycle add/sub/and/xor, multi-cycle shift-add multiply,
// registered result with valid/ready handshake, and an owned ZF/SF/OF condition-code register.
module alu_exec_unit #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err,
  output logic             zf,
  output logic             sf,
  output logic             of,
  input  logic [3:0]       cfun,
  output logic             cnd
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CW-1:0]    cnt;
  logic             set_cc_q;

  logic             is_mul, illegal;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_n, lo_n;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign is_mul    = (op == 3'b100) && MUL_EN;
  assign illegal   = (op > 3'b100) || ((op == 3'b100) && !MUL_EN);

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (op)
      3'b000: begin
        alu_res = a + b;
        alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        alu_res = a - b;
        alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  // {hi,lo} is the running product; lo starts as the multiplier and is shifted out LSB first.
  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign hi_n = sum[WIDTH:1];
  assign lo_n = {sum[0], lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      set_cc_q <= 1'b0;
      result   <= '0;
      out_err  <= 1'b0;
      zf       <= 1'b1;
      sf       <= 1'b0;
      of       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == IDLE || out_ready) begin
            if (in_valid) begin
              if (is_mul) begin
                state    <= MUL;
                mcand    <= a;
                lo       <= b;
                hi       <= '0;
                cnt      <= '0;
                set_cc_q <= set_cc;
              end else begin
                state   <= DONE;
                result  <= illegal ? '0 : alu_res;
                out_err <= illegal;
                if (set_cc && !illegal) begin
                  zf <= (alu_res == '0);
                  sf <= alu_res[WIDTH-1];
                  of <= alu_of;
                end
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        MUL: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= DONE;
            result  <= lo_n;
            out_err <= 1'b0;
            if (set_cc_q) begin
              zf <= (lo_n == '0);
              sf <= lo_n[WIDTH-1];
              of <= |hi_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnd = 1'b0;
    case (cfun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf ^ of) | zf;
      4'd2:    cnd = sf ^ of;
      4'd3:    cnd = zf;
      4'd4:    cnd = ~zf;
      4'd5:    cnd = ~(sf ^ of);
      4'd6:    cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked execute unit for the Y86-64 datapath and the successor to the combinational four-function ALU. It computes add, sub, and, and xor in one cycle, and an optional unsigned multiply over WIDTH cycles. It registers the result, owns the architectural condition-code register (ZF/SF/OF), and evaluates Y86 branch and cmov conditions from that register. It sits in the execute stage between register-read/decode and memory/write-back.

## Interface
- WIDTH, 64: operand and result width in bits; must be at least 4.
- MUL_EN, 1: 1 enables op 3'b100 (multiply); 0 makes op 3'b100 illegal.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  3  000 add, 001 sub (a−b), 010 and, 011 xor, 100 mul, 101–111 illegal.
- a, b  in  WIDTH  operands.
- set_cc  in  1  update the CC register when this operation completes.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- out_err  out  1  completed operation had an illegal op.
- zf, sf, of  out  1 each  CC register bits.
- cfun  in  4  condition select: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7–15 never.
- cnd  out  1  combinational condition value from the registered CC.

## Operation
- FSM states: IDLE, MUL, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- A request is accepted when in_valid & in_ready. The unit latches op, a, b, and set_cc at acceptance.
- Single-cycle ops (add/sub/and/xor) and illegal ops go directly to DONE.
- Multiply goes to MUL. It performs radix-2 shift-add, one multiplier bit per cycle, using a log2(WIDTH)+1-bit iteration counter. After WIDTH iterations it goes to DONE.
- In DONE, out_valid=1. If out_ready is high, the result is consumed:
  - with a simultaneous new acceptance, the unit moves to DONE or MUL for the new op;
  - otherwise it moves to IDLE.
- While in DONE with out_ready low, result, out_err, and out_valid hold stable.
- Arithmetic is modulo 2^WIDTH.
  - add OF: a and b have the same sign and the result sign differs.
  - sub OF: a and b have different signs and the result sign differs from a.
  - and/xor: OF=0.
  - mul: result is the low WIDTH bits of the unsigned product; OF=1 if the high WIDTH bits are nonzero.
- ZF = (result==0). SF = result[WIDTH-1].
- Illegal op: result=0, out_err=1, CC never updated.
- CC update: if the latched set_cc=1 and the op is legal, CC loads on the same edge that enters DONE.
- cnd, with zf/sf/of from the register:
  - le = (sf^of)|zf
  - l = sf^of
  - e = zf
  - ne = ~zf
  - ge = ~(sf^of)
  - g = ~(sf^of)&~zf

## Timing
- Reset values: state IDLE, out_valid=0, result=0, out_err=0, zf=1, sf=0, of=0, counter 0. in_ready=1 once reset is deasserted.
- Single-cycle op accepted at edge N: out_valid=1 and result valid after edge N. CC is updated at edge N.
- Multiply accepted at edge N: iterations occur at edges N+1..N+WIDTH. out_valid rises and CC updates after edge N+WIDTH. in_ready=0 throughout.
- Back-to-back throughput with out_ready held high: one single-cycle op per clock.
- A cnd evaluated in the cycle after a CC-updating completion reflects the new flags.
- Reset asserted mid-multiply or in DONE: immediate abort to the reset values. No result is produced and the CC does not change beyond its reset value.
- MUL_EN=0: op 100 completes as illegal in one cycle.

## Test plan
- Reset, then add a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 -> result 0x8000_0000_0000_0000, zf=0, sf=1, of=1, out_valid one cycle after accept.
- sub a=5, b=5, set_cc=1, then cfun=3/4/1 -> result 0, zf=1, cnd=1/0/1. A following xor with set_cc=0 leaves the CC unchanged.
- mul a=0x1_0000_0000, b=0x1_0000_0000 -> result 0, of=1, out_valid exactly 64 edges after accept; in_ready=0 during MUL.
- Stream of 8 add ops with in_valid and out_ready held high -> 8 results on 8 consecutive cycles, in order; with out_ready low for 3 cycles, result holds and in_ready=0.
- op=3'b110 with set_cc=1 -> result 0, out_err=1, CC unchanged; repeat op=3'b100 with MUL_EN=0 -> same behaviour.
- Assert rst at iteration 20 of a multiply -> out_valid=0, zf=1, sf=0, of=0, in_ready=1 after release. A new add completes normally.
